// File: rtl/ext_uart_pkg.sv
// rtl/ext_uart_pkg.sv - register map, status bits and FSM states for ext_uart
package ext_uart_pkg;

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_DIV    = 2'd2;
    localparam logic [1:0] REG_CTRL   = 2'd3;

    localparam int ST_RX_VALID   = 0;
    localparam int ST_TX_FULL    = 1;
    localparam int ST_TX_EMPTY   = 2;
    localparam int ST_RX_OVERRUN = 3;
    localparam int ST_FRAME_ERR  = 4;

    localparam logic [15:0] MIN_DIV = 16'd4;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_e;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_WAIT_HIGH
    } rx_state_e;

    function automatic logic [15:0] clamp_div(input logic [15:0] val);
        return (val < MIN_DIV) ? MIN_DIV : val;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - synchronous FIFO with registered first-word-fall-through output
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_full,
    output logic             o_empty
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count;
    logic [AW-1:0]    rd_next;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    assign count   = wr_ptr_q - rd_ptr_q;
    assign rd_next = rd_ptr_q[AW-1:0] + AW'(1);
    assign o_empty = (wr_ptr_q == rd_ptr_q);
    assign o_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign o_dout  = dout_q;

    always_comb begin
        do_pop   = i_pop & ~o_empty;
        // A full FIFO still accepts a push when the head leaves in the same cycle
        do_push  = i_push & (~o_full | do_pop);
        wr_ptr_d = wr_ptr_q + (AW+1)'(do_push);
        rd_ptr_d = rd_ptr_q + (AW+1)'(do_pop);
        dout_d   = dout_q;
        if (do_pop) begin
            if (count == (AW+1)'(1)) begin
                if (do_push) dout_d = i_din;
            end else begin
                dout_d = mem_q[rd_next];
            end
        end else if (o_empty && do_push) begin
            dout_d = i_din;
        end
    end

    always_ff @(posedge i_clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= i_din;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            dout_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            dout_q   <= dout_d;
        end
    end

endmodule

// File: rtl/ext_uart.sv
// rtl/ext_uart.sv - memory-mapped 8N1 UART on the external strobe/ack bus
module ext_uart
    import ext_uart_pkg::*;
#(
    parameter int          FIFO_DEPTH  = 16,
    parameter logic [15:0] DEFAULT_DIV = 16'd434
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [15:0] i_addr,
    input  logic        i_stb,
    input  logic [3:0]  i_we,
    input  logic [31:0] i_dat_w,
    output logic        o_ack,
    output logic [31:0] o_dat_r,
    input  logic        i_rx,
    output logic        o_tx,
    output logic        o_irq
);
    logic        ack_q, ack_d;
    logic [31:0] dat_r_q, dat_r_d;
    logic [15:0] div_q, div_d;
    logic        rx_ie_q, rx_ie_d, tx_ie_q, tx_ie_d;
    logic        overrun_q, overrun_d, frame_err_q, frame_err_d;

    tx_state_e   tx_state_q, tx_state_d;
    logic [15:0] tx_cnt_q, tx_cnt_d, tx_div_q, tx_div_d;
    logic [2:0]  tx_bit_q, tx_bit_d;
    logic [7:0]  tx_shift_q, tx_shift_d;
    logic        tx_q, tx_d;

    rx_state_e   rx_state_q, rx_state_d;
    logic        rx_s1_q, rx_s2_q, rx_prev_q;
    logic [15:0] rx_cnt_q, rx_cnt_d, rx_div_q, rx_div_d;
    logic [2:0]  rx_bit_q, rx_bit_d;
    logic [7:0]  rx_shift_q, rx_shift_d;

    logic        tx_push, tx_pop, tx_full, tx_fifo_empty;
    logic [7:0]  tx_dout;
    logic        rx_push, rx_pop, rx_full, rx_empty;
    logic [7:0]  rx_dout;
    logic        rx_push_req, rx_ferr_set;
    logic        rx_valid, tx_empty, txn, is_wr;
    logic [1:0]  sel;
    logic [15:0] div_new;
    logic [31:0] status, rd_data;
    logic        unused_bits;

    assign unused_bits = &{1'b0, i_addr[15:4], i_addr[1:0], i_dat_w[31:16]};

    assign rx_valid = ~rx_empty;
    assign tx_empty = tx_fifo_empty & (tx_state_q == TX_IDLE);
    assign o_ack    = ack_q;
    assign o_dat_r  = dat_r_q;
    assign o_tx     = tx_q;
    assign o_irq    = (rx_ie_q & rx_valid) | (tx_ie_q & tx_empty);

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (tx_push),
        .i_din   (i_dat_w[7:0]),
        .i_pop   (tx_pop),
        .o_dout  (tx_dout),
        .o_full  (tx_full),
        .o_empty (tx_fifo_empty)
    );

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (rx_push),
        .i_din   (rx_shift_q),
        .i_pop   (rx_pop),
        .o_dout  (rx_dout),
        .o_full  (rx_full),
        .o_empty (rx_empty)
    );

    // Bus side: every side effect is qualified by ack_d so it happens once per transaction
    always_comb begin
        ack_d   = i_stb & ~ack_q;
        txn     = ack_d;
        is_wr   = |i_we;
        sel     = i_addr[3:2];

        status                = '0;
        status[ST_RX_VALID]   = rx_valid;
        status[ST_TX_FULL]    = tx_full;
        status[ST_TX_EMPTY]   = tx_empty;
        status[ST_RX_OVERRUN] = overrun_q;
        status[ST_FRAME_ERR]  = frame_err_q;

        case (sel)
            REG_DATA:   rd_data = rx_valid ? {23'b0, 1'b1, rx_dout} : 32'b0;
            REG_STATUS: rd_data = status;
            REG_DIV:    rd_data = {16'b0, div_q};
            default:    rd_data = {30'b0, tx_ie_q, rx_ie_q};
        endcase
        dat_r_d = (txn & ~is_wr) ? rd_data : 32'b0;

        tx_push = txn & i_we[0] & (sel == REG_DATA);
        rx_pop  = txn & ~is_wr & (sel == REG_DATA) & rx_valid;

        div_new = div_q;
        if (i_we[0]) div_new[7:0]  = i_dat_w[7:0];
        if (i_we[1]) div_new[15:8] = i_dat_w[15:8];
        div_d = (txn & is_wr & (sel == REG_DIV)) ? clamp_div(div_new) : div_q;

        rx_ie_d = rx_ie_q;
        tx_ie_d = tx_ie_q;
        if (txn & i_we[0] & (sel == REG_CTRL)) begin
            rx_ie_d = i_dat_w[0];
            tx_ie_d = i_dat_w[1];
        end

        overrun_d   = overrun_q;
        frame_err_d = frame_err_q;
        if (txn & i_we[0] & (sel == REG_STATUS)) begin
            if (i_dat_w[ST_RX_OVERRUN]) overrun_d   = 1'b0;
            if (i_dat_w[ST_FRAME_ERR])  frame_err_d = 1'b0;
        end
        rx_push = rx_push_req & ~rx_full;
        if (rx_push_req & rx_full) overrun_d   = 1'b1;
        if (rx_ferr_set)           frame_err_d = 1'b1;
    end

    // o_tx is registered from the current state, so each level lags its state by one clock
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_div_d   = tx_div_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_pop     = 1'b0;
        case (tx_state_q)
            TX_START: tx_d = 1'b0;
            TX_DATA:  tx_d = tx_shift_q[0];
            default:  tx_d = 1'b1;
        endcase
        if (tx_state_q != TX_IDLE) begin
            tx_cnt_d = (tx_cnt_q == tx_div_q - 16'd1) ? 16'd0 : tx_cnt_q + 16'd1;
        end
        case (tx_state_q)
            TX_IDLE: begin
                if (!tx_fifo_empty) begin
                    tx_pop     = 1'b1;
                    tx_shift_d = tx_dout;
                    tx_div_d   = div_q;
                    tx_cnt_d   = 16'd0;
                    tx_state_d = TX_START;
                end
            end
            TX_START: begin
                if (tx_cnt_q == tx_div_q - 16'd1) begin
                    tx_bit_d   = 3'd0;
                    tx_state_d = TX_DATA;
                end
            end
            TX_DATA: begin
                if (tx_cnt_q == tx_div_q - 16'd1) begin
                    tx_shift_d = {1'b0, tx_shift_q[7:1]};
                    tx_bit_d   = tx_bit_q + 3'd1;
                    if (tx_bit_q == 3'd7) tx_state_d = TX_STOP;
                end
            end
            default: begin
                if (tx_cnt_q == tx_div_q - 16'd1) begin
                    if (!tx_fifo_empty) begin
                        tx_pop     = 1'b1;
                        tx_shift_d = tx_dout;
                        tx_div_d   = div_q;
                        tx_state_d = TX_START;
                    end else begin
                        tx_state_d = TX_IDLE;
                    end
                end
            end
        endcase
    end

    always_comb begin
        rx_state_d  = rx_state_q;
        rx_cnt_d    = rx_cnt_q + 16'd1;
        rx_div_d    = rx_div_q;
        rx_bit_d    = rx_bit_q;
        rx_shift_d  = rx_shift_q;
        rx_push_req = 1'b0;
        rx_ferr_set = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                rx_cnt_d = 16'd0;
                if (rx_prev_q & ~rx_s2_q) begin
                    rx_div_d   = div_q;
                    rx_state_d = RX_START;
                end
            end
            RX_START: begin
                if (rx_cnt_q == {1'b0, rx_div_q[15:1]} - 16'd1) begin
                    rx_cnt_d   = 16'd0;
                    rx_bit_d   = 3'd0;
                    rx_state_d = rx_s2_q ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (rx_cnt_q == rx_div_q - 16'd1) begin
                    rx_cnt_d   = 16'd0;
                    rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
                    rx_bit_d   = rx_bit_q + 3'd1;
                    if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
                end
            end
            RX_STOP: begin
                if (rx_cnt_q == rx_div_q - 16'd1) begin
                    rx_cnt_d = 16'd0;
                    if (rx_s2_q) begin
                        rx_push_req = 1'b1;
                        rx_state_d  = RX_IDLE;
                    end else begin
                        rx_ferr_set = 1'b1;
                        rx_state_d  = RX_WAIT_HIGH;
                    end
                end
            end
            default: begin
                rx_cnt_d = 16'd0;
                if (rx_s2_q) rx_state_d = RX_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ack_q       <= 1'b0;
            dat_r_q     <= '0;
            div_q       <= DEFAULT_DIV;
            rx_ie_q     <= 1'b0;
            tx_ie_q     <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
            tx_state_q  <= TX_IDLE;
            tx_cnt_q    <= '0;
            tx_div_q    <= DEFAULT_DIV;
            tx_bit_q    <= '0;
            tx_shift_q  <= '0;
            tx_q        <= 1'b1;
            rx_state_q  <= RX_IDLE;
            rx_s1_q     <= 1'b1;
            rx_s2_q     <= 1'b1;
            rx_prev_q   <= 1'b1;
            rx_cnt_q    <= '0;
            rx_div_q    <= DEFAULT_DIV;
            rx_bit_q    <= '0;
            rx_shift_q  <= '0;
        end else begin
            ack_q       <= ack_d;
            dat_r_q     <= dat_r_d;
            div_q       <= div_d;
            rx_ie_q     <= rx_ie_d;
            tx_ie_q     <= tx_ie_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
            tx_state_q  <= tx_state_d;
            tx_cnt_q    <= tx_cnt_d;
            tx_div_q    <= tx_div_d;
            tx_bit_q    <= tx_bit_d;
            tx_shift_q  <= tx_shift_d;
            tx_q        <= tx_d;
            rx_state_q  <= rx_state_d;
            rx_s1_q     <= i_rx;
            rx_s2_q     <= rx_s1_q;
            rx_prev_q   <= rx_s2_q;
            rx_cnt_q    <= rx_cnt_d;
            rx_div_q    <= rx_div_d;
            rx_bit_q    <= rx_bit_d;
            rx_shift_q  <= rx_shift_d;
        end
    end

endmodule

// File: tb/tb_ext_uart.sv
// tb/tb_ext_uart.sv - scoreboard bench for ext_uart bus, TX and RX paths
module tb_ext_uart;

    logic        i_clk;
    logic        i_rst_n;
    logic [15:0] i_addr;
    logic        i_stb;
    logic [3:0]  i_we;
    logic [31:0] i_dat_w;
    logic        o_ack;
    logic [31:0] o_dat_r;
    logic        i_rx;
    logic        o_tx;
    logic        o_irq;

    ext_uart #(.FIFO_DEPTH(16), .DEFAULT_DIV(16'd434)) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_addr  (i_addr),
        .i_stb   (i_stb),
        .i_we    (i_we),
        .i_dat_w (i_dat_w),
        .o_ack   (o_ack),
        .o_dat_r (o_dat_r),
        .i_rx    (i_rx),
        .o_tx    (o_tx),
        .o_irq   (o_irq)
    );

    int          n_cmp = 0;
    int          n_fail = 0;
    int          last_lat;
    int          tb_div = 434;
    bit          mon_en = 1'b1;
    logic        prev_ack = 1'b0;
    logic [31:0] rd_exp_q[$];
    logic [7:0]  tx_exp_q[$];
    logic [7:0]  mon_b;
    logic        mon_stop;
    int          mon_d;
    logic [39:0] cap, wave;

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic bus(input logic [1:0] r, input logic [3:0] we, input logic [31:0] wd, input bit hold);
        i_addr  = {12'h0, r, 2'b00};
        i_we    = we;
        i_dat_w = wd;
        i_stb   = 1'b1;
        last_lat = 0;
        do begin
            @(posedge i_clk); #2;
            last_lat++;
        end while (!o_ack && last_lat < 10);
        if (!o_ack) check("ack_timeout", o_ack, 1);
        if (!hold) begin
            i_stb = 1'b0;
            @(posedge i_clk); #2;
        end
    endtask

    task automatic rd(input logic [1:0] r, input logic [31:0] exp);
        rd_exp_q.push_back(exp);
        bus(r, 4'h0, 32'h0, 1'b0);
    endtask

    task automatic wr(input logic [1:0] r, input logic [31:0] d);
        bus(r, 4'hF, d, 1'b0);
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop, input int d);
        i_rx = 1'b0;
        repeat (d) @(posedge i_clk); #2;
        for (int k = 0; k < 8; k++) begin
            i_rx = b[k];
            repeat (d) @(posedge i_clk); #2;
        end
        i_rx = stop;
        repeat (stop ? d : 3 * d) @(posedge i_clk); #2;
        i_rx = 1'b1;
        repeat (2) @(posedge i_clk); #2;
    endtask

    // Read-data scoreboard: every acked read pops the next expected value
    initial begin
        forever begin
            @(posedge i_clk); #1;
            if (o_ack) begin
                check("ack_single_cycle", prev_ack, 0);
                if (i_we == 4'h0) begin
                    if (rd_exp_q.size() == 0) begin
                        n_cmp++; n_fail++;
                        $display("FAIL rd_unexpected: got 0x%0h with no expected read", o_dat_r);
                    end else begin
                        check("rd_data", o_dat_r, rd_exp_q.pop_front());
                    end
                end
            end else begin
                check("dat_r_idle", o_dat_r, 0);
            end
            prev_ack = o_ack;
        end
    end

    // Serial TX monitor: decodes frames at tb_div and compares against queued bytes
    initial begin
        forever begin
            @(posedge i_clk); #1;
            if (mon_en && i_rst_n && o_tx == 1'b0) begin
                mon_d = tb_div;
                repeat (mon_d / 2) begin @(posedge i_clk); #1; end
                for (int k = 0; k < 8; k++) begin
                    repeat (mon_d) begin @(posedge i_clk); #1; end
                    mon_b[k] = o_tx;
                end
                repeat (mon_d) begin @(posedge i_clk); #1; end
                mon_stop = o_tx;
                if (mon_en) begin
                    if (tx_exp_q.size() == 0) begin
                        n_cmp++; n_fail++;
                        $display("FAIL tx_unexpected: got byte 0x%0h with none expected", mon_b);
                    end else begin
                        check("tx_byte", mon_b, tx_exp_q.pop_front());
                        check("tx_stop", mon_stop, 1);
                    end
                end
            end
        end
    end

    initial begin
        #1000000;
        n_fail++;
        $display("FAIL watchdog: simulation did not complete");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        i_rst_n = 1'b0; i_stb = 1'b0; i_we = 4'h0; i_addr = 16'h0; i_dat_w = 32'h0; i_rx = 1'b1;
        repeat (3) @(posedge i_clk); #2;
        i_rst_n = 1'b1;
        check("rst_tx", o_tx, 1);
        check("rst_ack", o_ack, 0);
        check("rst_dat_r", o_dat_r, 0);
        check("rst_irq", o_irq, 0);
        @(posedge i_clk); #2;

        rd(2'd0, 32'h0);   check("ack_latency_data", last_lat, 1);
        rd(2'd1, 32'h4);   check("ack_latency_status", last_lat, 1);
        rd(2'd2, 32'd434); check("ack_latency_div", last_lat, 1);
        rd(2'd3, 32'h0);   check("ack_latency_ctrl", last_lat, 1);

        wr(2'd2, 32'd2);
        rd(2'd2, 32'd4);

        // Single 0x55 frame at divisor 4, checked clock by clock
        tb_div = 4;
        tx_exp_q.push_back(8'h55);
        bus(2'd0, 4'h1, 32'h55, 1'b1);
        i_stb = 1'b0;
        @(posedge i_clk); #1;
        check("tx_latency_e1", o_tx, 1);
        @(posedge i_clk); #1;
        check("tx_latency_e2", o_tx, 0);
        for (int j = 0; j < 40; j++) begin
            if (j / 4 == 0)      wave[j] = 1'b0;
            else if (j / 4 == 9) wave[j] = 1'b1;
            else                 wave[j] = ((8'h55 >> (j / 4 - 1)) & 8'h1) != 8'h0;
            cap[j] = o_tx;
            @(posedge i_clk); #1;
        end
        check("tx_waveform_55", cap, wave);
        #1;
        rd(2'd1, 32'h4);

        // 17 back-to-back pushes fill the FIFO behind the first frame; an 18th is dropped
        for (int i = 0; i < 17; i++) begin
            tx_exp_q.push_back(8'hA0 + 8'(i));
            bus(2'd0, 4'h1, 32'hA0 + 32'(i), 1'b1);
        end
        bus(2'd0, 4'h1, 32'hEE, 1'b1);
        rd(2'd1, 32'h2);
        repeat (760) @(posedge i_clk); #2;
        check("tx_drained", tx_exp_q.size(), 0);
        rd(2'd1, 32'h4);

        // Receive 0xA3 at divisor 8 with rx interrupt enabled
        wr(2'd2, 32'd8);
        tb_div = 8;
        wr(2'd3, 32'h1);
        send_rx(8'hA3, 1'b1, 8);
        repeat (4) @(posedge i_clk); #2;
        check("irq_rx_rise", o_irq, 1);
        rd(2'd0, 32'h1A3);
        rd(2'd0, 32'h0);
        check("irq_rx_fall", o_irq, 0);

        // Overrun: 17 frames into a 16-deep FIFO
        for (int i = 0; i < 17; i++) send_rx(8'h10 + 8'(i), 1'b1, 8);
        rd(2'd1, 32'hD);
        wr(2'd1, 32'h8);
        rd(2'd1, 32'h5);
        for (int i = 0; i < 16; i++) rd(2'd0, 32'h110 + 32'(i));
        rd(2'd0, 32'h0);
        rd(2'd1, 32'h4);

        // Stop bit low: frame error, no byte
        send_rx(8'h5A, 1'b0, 8);
        rd(2'd1, 32'h14);
        rd(2'd0, 32'h0);
        wr(2'd1, 32'h10);
        rd(2'd1, 32'h4);

        // Two-clock glitch on idle line is rejected silently
        i_rx = 1'b0;
        repeat (2) @(posedge i_clk); #2;
        i_rx = 1'b1;
        repeat (20) @(posedge i_clk); #2;
        rd(2'd1, 32'h4);
        rd(2'd0, 32'h0);

        // Reset during a start bit forces o_tx high without a clock edge
        wr(2'd2, 32'd4);
        tb_div = 4;
        mon_en = 1'b0;
        bus(2'd0, 4'h1, 32'h00, 1'b1);
        i_stb = 1'b0;
        repeat (3) @(posedge i_clk); #3;
        check("tx_low_before_rst", o_tx, 0);
        i_rst_n = 1'b0;
        #1;
        check("tx_async_rst", o_tx, 1);
        repeat (2) @(posedge i_clk); #2;
        i_rst_n = 1'b1;
        @(posedge i_clk); #2;
        rd(2'd2, 32'd434);
        rd(2'd1, 32'h4);

        repeat (10) @(posedge i_clk); #2;
        check("rd_queue_empty", rd_exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
